// File: rtl/adc_sampler_if.sv
// ADC sampler consumer-side bundle.
// Master is the sampler; slave is the register file side.
interface adc_sampler_if;
  logic [7:0] JA;
  logic       ack;
  logic       conv_start;
  logic [7:0] sample;
  logic       sample_ready;
  logic       overrun;
  logic       busy;

  modport master (
    input  JA,
    input  ack,
    output conv_start,
    output sample,
    output sample_ready,
    output overrun,
    output busy
  );

  modport slave (
    output JA,
    output ack,
    input  conv_start,
    input  sample,
    input  sample_ready,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/adc_sampler.sv
// Paced 8-bit parallel ADC front-end with box-car averaging.
// Publishes averaged samples with sticky ready/overrun flags.
module adc_sampler #(
  parameter int DIV         = 500,
  parameter int CONV_CYCLES = 8,
  parameter int AVG_LOG2    = 2
) (
  input logic           clock,
  input logic           ctrl_reset,
  adc_sampler_if.master bus
);

  localparam int DW = $clog2(DIV);
  localparam int WW = $clog2(CONV_CYCLES + 1);
  localparam int AW = 8 + AVG_LOG2;
  localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(CONV_CYCLES - 1);
  localparam logic [NW-1:0] N_LAST    = NW'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    CAPTURE,
    PUBLISH
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [7:0]    ja_meta;
  logic [7:0]    ja_sync;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [WW-1:0] wait_cnt;
  logic [AW-1:0] acc;
  logic [NW-1:0] n;
  logic          last;
  logic          publish;

  assign tick    = (div_cnt == DIV_LAST);
  assign last    = (n == N_LAST);
  assign publish = (state == PUBLISH);

  // Two-flop synchronizer for the asynchronous ADC byte.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      ja_meta <= '0;
      ja_sync <= '0;
    end else begin
      ja_meta <= bus.JA;
      ja_sync <= ja_meta;
    end
  end

  // Free-running conversion pacing divider.
  always_ff @(posedge clock) begin
    if (ctrl_reset || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state; ticks outside IDLE are ignored.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (tick) state_n = START;
      START:   state_n = WAIT;
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_n = CAPTURE;
        end
      end
      CAPTURE: state_n = last ? PUBLISH : IDLE;
      PUBLISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Conversion wait counter and averaging accumulator.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      wait_cnt <= '0;
      acc      <= '0;
      n        <= '0;
    end else begin
      unique case (state)
        START: wait_cnt <= '0;
        WAIT:  wait_cnt <= wait_cnt + WW'(1);
        CAPTURE: begin
          acc <= acc + AW'(ja_sync);
          if (!last) n <= n + NW'(1);
        end
        PUBLISH: begin
          acc <= '0;
          n   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; an ack racing a publish keeps ready set.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      bus.conv_start   <= 1'b0;
      bus.busy         <= 1'b0;
      bus.sample       <= '0;
      bus.sample_ready <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.conv_start <= (state_n == START);
      bus.busy       <= (state_n != IDLE);
      if (publish) begin
        bus.sample <= acc[AW-1 -: 8];
      end
      bus.sample_ready <= publish
                        | (bus.sample_ready & ~bus.ack);
      bus.overrun <= ~bus.ack
                   & (bus.overrun
                      | (publish & bus.sample_ready));
    end
  end

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: two instances (no averaging, 4x).
// Outputs compared each cycle with a timeline-based model.
module tb_adc_sampler;

  localparam int DIV = 16;
  localparam int CC  = 4;

  logic clock = 1'b0;
  logic ctrl_reset = 1'b1;

  adc_sampler_if bus0 ();
  adc_sampler_if bus2 ();

  adc_sampler #(
    .DIV(DIV),
    .CONV_CYCLES(CC),
    .AVG_LOG2(0)
  ) dut0 (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .bus(bus0.master)
  );

  adc_sampler #(
    .DIV(DIV),
    .CONV_CYCLES(CC),
    .AVG_LOG2(2)
  ) dut2 (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .bus(bus2.master)
  );

  always #5 clock = ~clock;

  int c;
  int n_assert;
  int n_fail;

  logic [7:0] ja_log [64];
  logic [7:0] m_sample [2];
  logic       m_ready [2];
  logic       m_ovr [2];
  logic       m_pend [2];
  int         m_sum [2];
  int         m_cnt [2];
  logic [7:0] vals [4];

  function automatic int navg(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic is_conv(input int cc);
    return cc >= DIV && (cc - DIV) % DIV == 0;
  endfunction

  function automatic logic in_conv(input int cc);
    return cc >= DIV && (cc - DIV) % DIV <= CC + 1;
  endfunction

  function automatic logic is_cap(input int cc);
    return cc >= DIV + 1 + CC
        && (cc - DIV - 1 - CC) % DIV == 0;
  endfunction

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s c=%0d observed=%b expected=%b",
             tag, c, obs, exp);
    end
  endtask

  task automatic chk8(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s c=%0d observed=%h expected=%h",
             tag, c, obs, exp);
    end
  endtask

  task automatic model_reset();
    c = 0;
    for (int d = 0; d < 2; d++) begin
      m_sample[d] = 8'h00;
      m_ready[d]  = 1'b0;
      m_ovr[d]    = 1'b0;
      m_pend[d]   = 1'b0;
      m_sum[d]    = 0;
      m_cnt[d]    = 0;
    end
  endtask

  task automatic check_one(input int d,
                           input logic cs,
                           input logic bsy,
                           input logic rdy,
                           input logic ovr,
                           input logic [7:0] smp);
    chk1($sformatf("conv_start%0d", d), cs, is_conv(c));
    chk1($sformatf("busy%0d", d), bsy,
         in_conv(c) | m_pend[d]);
    chk1($sformatf("ready%0d", d), rdy, m_ready[d]);
    chk1($sformatf("overrun%0d", d), ovr, m_ovr[d]);
    chk8($sformatf("sample%0d", d), smp, m_sample[d]);
  endtask

  task automatic update(input int d, input logic a);
    int tick;
    if (m_pend[d]) begin
      m_sample[d] = 8'(m_sum[d] / navg(d));
      m_ovr[d] = a ? 1'b0 : (m_ovr[d] | m_ready[d]);
      m_ready[d] = 1'b1;
      m_sum[d] = 0;
      m_cnt[d] = 0;
      m_pend[d] = 1'b0;
    end else if (a) begin
      m_ready[d] = 1'b0;
      m_ovr[d] = 1'b0;
    end
    if (is_cap(c)) begin
      tick = c - 2 - CC;
      m_sum[d] += int'(ja_log[(tick + CC) % 64]);
      m_cnt[d]++;
      if (m_cnt[d] == navg(d)) m_pend[d] = 1'b1;
    end
  endtask

  task automatic step(input logic [7:0] ja,
                      input logic a0,
                      input logic a2);
    bus0.JA = ja;
    bus2.JA = ja;
    bus0.ack = a0;
    bus2.ack = a2;
    ja_log[c % 64] = ja;
    @(negedge clock);
    check_one(0, bus0.conv_start, bus0.busy,
              bus0.sample_ready, bus0.overrun,
              bus0.sample);
    check_one(1, bus2.conv_start, bus2.busy,
              bus2.sample_ready, bus2.overrun,
              bus2.sample);
    update(0, a0);
    update(1, a2);
    c++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    ctrl_reset = 1'b1;
    bus0.ack = 1'b0;
    bus2.ack = 1'b0;
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] v;
    n_assert = 0;
    n_fail = 0;
    vals[0] = 8'h10;
    vals[1] = 8'h20;
    vals[2] = 8'h30;
    vals[3] = 8'h41;
    bus0.JA = 8'h00;
    bus2.JA = 8'h00;
    bus0.ack = 1'b0;
    bus2.ack = 1'b0;
    ctrl_reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    model_reset();

    // pass-through with constant full-scale input
    for (int i = 0; i < 23; i++) step(8'hFF, 1'b0, 1'b0);
    chk8("pass_sample", bus0.sample, 8'hFF);
    chk1("pass_ready", bus0.sample_ready, 1'b1);
    chk1("pass_busy", bus0.busy, 1'b0);
    for (int i = 0; i < 17; i++) step(8'hFF, 1'b0, 1'b0);

    // averaging of four directed conversions
    do_reset();
    for (int i = 0; i < 80; i++) begin
      v = (c < DIV) ? 8'h00 : vals[c / DIV - 1];
      step(v, 1'b0, 1'b0);
    end
    chk8("avg_sample", bus2.sample, 8'h28);
    chk1("avg_ready", bus2.sample_ready, 1'b1);
    chk1("avg_no_ovr", bus2.overrun, 1'b0);
    chk1("ovr_set", bus0.overrun, 1'b1);
    chk8("ovr_hold", bus0.sample, 8'h41);

    // single ack clears both flags, sample kept
    step(8'h55, 1'b1, 1'b1);
    chk1("ack_ready", bus0.sample_ready, 1'b0);
    chk1("ack_ovr", bus0.overrun, 1'b0);
    chk8("ack_sample", bus0.sample, 8'h41);

    // ack coincident with every publish of dut0
    for (int i = 0; i < 50; i++) begin
      v = 8'($urandom);
      step(v, m_pend[0], 1'b0);
    end
    chk1("race_ready", bus0.sample_ready, 1'b1);
    chk1("race_ovr", bus0.overrun, 1'b0);

    // reset during WAIT of the second conversion
    do_reset();
    for (int i = 0; i < 34; i++) step(8'($urandom), 1'b0, 1'b0);
    chk1("midwait_busy", bus2.busy, 1'b1);
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(8'($urandom), 1'b0, 1'b0);
    end

    // long random run with sporadic acks
    for (int i = 0; i < 600; i++) begin
      step(8'($urandom),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
